// File: rtl/shift_cmd_queue.sv
// Command FIFO that feeds a barrel shifter: a circular buffer of {x, shift, lr} entries
// with valid/ready on both sides, synchronous flush and a sticky overflow flag.
module shift_cmd_queue #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [7:0]               in_x,
    input  logic [2:0]               in_shift,
    input  logic                     in_lr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [7:0]               out_x,
    output logic [2:0]               out_shift,
    output logic                     out_lr,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     dropped
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [11:0]   mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic          push;
    logic          pop;

    // Handshakes depend only on registered occupancy, so ready/valid never
    // combinationally follow the opposite side.
    assign in_ready  = (count != CW'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign {out_x, out_shift, out_lr} = mem[rptr];

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wptr] <= {in_x, in_shift, in_lr};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            dropped <= 1'b0;
        end else if (flush) begin
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            dropped <= 1'b0;
        end else begin
            if (push) begin
                wptr <= wptr + PW'(1);
            end
            if (pop) begin
                rptr <= rptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (in_valid && !in_ready) begin
                dropped <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_shift_cmd_queue.sv
// Scoreboard bench for shift_cmd_queue: directed scenarios followed by random traffic,
// checked against an occupancy/queue model and a head-of-queue monitor.
module tb_shift_cmd_queue;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_x;
    logic [2:0] in_shift;
    logic       in_lr;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_x;
    logic [2:0] out_shift;
    logic       out_lr;
    logic [$clog2(DEPTH):0] count;
    logic       dropped;

    int n_checks = 0;
    int n_errors = 0;
    int n_pops   = 0;

    logic [11:0] exp_q[$];
    int          m_cnt  = 0;
    logic        m_drop = 1'b0;

    shift_cmd_queue #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_shift  (in_shift),
        .in_lr     (in_lr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_x     (out_x),
        .out_shift (out_shift),
        .out_lr    (out_lr),
        .count     (count),
        .dropped   (dropped)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: whenever a head is presented it must match the oldest expected command.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                chk("head_unexpected", 1, 0);
            end else begin
                chk("head", int'({out_x, out_shift, out_lr}), int'(exp_q[0]));
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    n_pops++;
                end
            end
        end
    end

    // Reference model: occupancy and overflow flag from the queue rules, evaluated
    // after the monitor so a same-cycle flush cannot starve the head comparison.
    always @(negedge clk) begin
        #1;
        if (!rst_n) begin
            m_cnt  = 0;
            m_drop = 1'b0;
            exp_q.delete();
        end else begin
            chk("count", int'(count), m_cnt);
            chk("in_ready", int'(in_ready), int'(m_cnt != DEPTH));
            chk("out_valid", int'(out_valid), int'(m_cnt != 0));
            chk("dropped", int'(dropped), int'(m_drop));
            if (flush) begin
                m_cnt  = 0;
                m_drop = 1'b0;
                exp_q.delete();
            end else begin
                bit do_push;
                bit do_pop;
                do_push = in_valid && (m_cnt < DEPTH);
                do_pop  = out_ready && (m_cnt > 0);
                if (in_valid && m_cnt == DEPTH) m_drop = 1'b1;
                if (do_push) exp_q.push_back({in_x, in_shift, in_lr});
                m_cnt = m_cnt + int'(do_push) - int'(do_pop);
            end
        end
    end

    initial begin
        int idx;
        int pops0;
        bit acc;

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_x = '0; in_shift = '0; in_lr = 1'b0;
        #3;
        chk("rst_count", int'(count), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_dropped", int'(dropped), 0);
        @(posedge clk); @(posedge clk); #2;
        rst_n = 1'b1;

        // Single command, minimum latency of one cycle
        out_ready = 1'b1; in_valid = 1'b1; in_x = 8'hB5; in_shift = 3'd3; in_lr = 1'b1;
        chk("single_no_bypass", int'(out_valid), 0);
        step();
        in_valid = 1'b0;
        chk("single_valid", int'(out_valid), 1);
        chk("single_x", int'(out_x), 8'hB5);
        chk("single_shift", int'(out_shift), 3);
        chk("single_lr", int'(out_lr), 1);
        step();
        chk("single_gone", int'(out_valid), 0);
        chk("single_count", int'(count), 0);

        // Fill and stall
        out_ready = 1'b0; in_shift = 3'd1; in_lr = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            in_valid = 1'b1; in_x = 8'(i);
            step();
            if (i == 4) begin
                chk("fill_count", int'(count), 4);
                chk("fill_in_ready", int'(in_ready), 0);
                chk("fill_not_dropped", int'(dropped), 0);
            end
        end
        chk("fill_dropped", int'(dropped), 1);
        chk("fill_head", int'(out_x), 8'h01);

        // Full with consumer ready: pop only, then push under continued pop
        in_x = 8'h06; out_ready = 1'b1;
        step();
        chk("full_pop_count", int'(count), 3);
        chk("full_pop_ready", int'(in_ready), 1);
        step();
        chk("full_pushpop_count", int'(count), 3);
        in_valid = 1'b0; out_ready = 1'b0;

        // Flush wins over a concurrent push
        flush = 1'b1; in_valid = 1'b1; in_x = 8'hEE;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_count", int'(count), 0);
        chk("flush_out_valid", int'(out_valid), 0);
        chk("flush_dropped", int'(dropped), 0);

        // Wrap-around: ten commands through a four-entry buffer
        pops0 = n_pops;
        idx = 0;
        for (int c = 0; c < 200 && idx < 10; c++) begin
            in_valid = 1'b1; in_x = 8'(8'h10 + idx); in_shift = 3'(idx); in_lr = idx[0];
            out_ready = 1'($urandom);
            acc = in_ready;
            step();
            if (acc) idx++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (6) step();
        chk("wrap_pushed", idx, 10);
        chk("wrap_popped", n_pops - pops0, 10);

        // Asynchronous reset between edges
        out_ready = 1'b0; in_valid = 1'b1; in_x = 8'h5A;
        step();
        in_x = 8'h5B;
        step();
        in_valid = 1'b0;
        chk("pre_rst_count", int'(count), 2);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_count", int'(count), 0);
        chk("arst_out_valid", int'(out_valid), 0);
        chk("arst_in_ready", int'(in_ready), 1);
        @(posedge clk); #2;
        rst_n = 1'b1;

        // First push after reset becomes the head
        in_valid = 1'b1; in_x = 8'hC3; in_shift = 3'd7; in_lr = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("post_rst_head", int'(out_x), 8'hC3);

        // Random traffic
        for (int c = 0; c < 600; c++) begin
            in_valid  = ($urandom_range(0, 2) != 0);
            out_ready = 1'($urandom);
            flush     = ($urandom_range(0, 39) == 0);
            in_x      = 8'($urandom);
            in_shift  = 3'($urandom);
            in_lr     = 1'($urandom);
            step();
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (DEPTH + 2) step();
        chk("drain_empty", exp_q.size(), 0);
        chk("drain_count", int'(count), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
